// File: rtl/hpdl_multi_display_if.sv
// hpdl_multi_display_if: valid/ready byte stream feeding the display engine
interface hpdl_multi_display_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  modport master (output in_valid, in_data, input in_ready);
  modport slave (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/hpdl_multi_display.sv
// hpdl_multi_display: character buffer editor plus timed refresh of chained HPDL-1414 parts
module hpdl_multi_display #(
  parameter int NUM_CHIPS = 4,
  parameter int SETUP_CYC = 8,
  parameter int WR_CYC = 16,
  parameter int HOLD_CYC = 8,
  parameter int BLINK_DIV = 2**22,
  parameter logic [7:0] CARET_CHR = 8'h5F,
  parameter logic [7:0] BLANK_CHR = 8'h20,
  localparam int DIGITS = 4 * NUM_CHIPS,
  localparam int CW = $clog2(DIGITS + 1)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  hpdl_multi_display_if.slave  s,
  input  logic                 mode_scroll,
  input  logic                 caret_en,
  output logic [6:0]           HPDL_D,
  output logic [1:0]           HPDL_A,
  output logic [NUM_CHIPS-1:0] HPDL_WR_N,
  output logic [CW-1:0]        cursor
);
  localparam int DW = $clog2(DIGITS);
  localparam int MAXC = ((SETUP_CYC > WR_CYC ? SETUP_CYC : WR_CYC) > HOLD_CYC) ?
                        (SETUP_CYC > WR_CYC ? SETUP_CYC : WR_CYC) : HOLD_CYC;
  localparam int CNTW = $clog2(MAXC + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  typedef enum logic [1:0] {S_SETUP, S_STROBE, S_HOLD} state_t;

  logic [6:0]      r_buf [DIGITS];
  logic [CW-1:0]   r_cursor;
  logic            r_clr;
  logic [DW-1:0]   r_clr_idx;
  logic [BW-1:0]   r_bcnt;
  logic            r_phase;
  state_t          r_state;
  logic [CNTW-1:0] r_cnt;
  logic [DW-1:0]   r_digit;

  logic            w_print;
  logic            w_full;
  logic [CW-1:0]   w_cm1;
  logic            w_last;
  logic [DW-1:0]   w_next;
  logic            w_caret;

  assign s.in_ready = !r_clr;
  assign cursor = r_cursor;
  assign w_print = !s.in_data[7] && (s.in_data[6:5] != 2'b00);
  assign w_full = r_cursor == CW'(DIGITS);
  assign w_cm1 = r_cursor - CW'(1);
  assign w_last = r_cnt == (r_state == S_SETUP  ? CNTW'(SETUP_CYC - 1) :
                            r_state == S_STROBE ? CNTW'(WR_CYC - 1) : CNTW'(HOLD_CYC - 1));
  assign w_next = (r_digit == DW'(DIGITS - 1)) ? '0 : r_digit + 1'b1;
  assign w_caret = caret_en && !r_phase && (CW'(w_next) == r_cursor);

  // Edit path: apply accepted bytes, or blank one entry per cycle while clearing
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DIGITS; i++) r_buf[i] <= BLANK_CHR[6:0];
      r_cursor <= '0;
      r_clr <= 1'b0;
      r_clr_idx <= '0;
    end else if (r_clr) begin
      r_buf[r_clr_idx] <= BLANK_CHR[6:0];
      r_clr_idx <= r_clr_idx + 1'b1;
      r_clr <= r_clr_idx != DW'(DIGITS - 1);
    end else if (s.in_valid) begin
      if (w_print && !w_full) begin
        r_buf[r_cursor[DW-1:0]] <= s.in_data[6:0];
        r_cursor <= r_cursor + CW'(1);
      end else if (w_print && mode_scroll) begin
        for (int i = 0; i < DIGITS - 1; i++) r_buf[i] <= r_buf[i+1];
        r_buf[DIGITS-1] <= s.in_data[6:0];
      end else if (w_print) begin
        r_buf[0] <= s.in_data[6:0];
        r_cursor <= CW'(1);
      end else if (s.in_data == 8'h08 && r_cursor != '0) begin
        r_cursor <= w_cm1;
        r_buf[w_cm1[DW-1:0]] <= BLANK_CHR[6:0];
      end else if (s.in_data == 8'h0D) begin
        r_cursor <= '0;
      end else if (s.in_data == 8'h0C) begin
        r_clr <= 1'b1;
        r_clr_idx <= '0;
        r_cursor <= '0;
      end
    end
  end

  // Caret blink: toggle phase every BLINK_DIV cycles, starting with the character visible
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bcnt <= '0;
      r_phase <= 1'b1;
    end else if (r_bcnt == BW'(BLINK_DIV - 1)) begin
      r_bcnt <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end

  // Scan FSM: latch addr/data entering SETUP, pulse one chip's WR_N during STROBE, then HOLD
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_SETUP;
      r_cnt <= '0;
      r_digit <= '0;
      HPDL_WR_N <= '1;
      HPDL_A <= 2'b11;
      HPDL_D <= '0;
    end else if (!w_last) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
      if (r_state == S_SETUP) begin
        r_state <= S_STROBE;
        HPDL_WR_N <= ~(NUM_CHIPS'(1) << (r_digit >> 2));
      end else if (r_state == S_STROBE) begin
        r_state <= S_HOLD;
        HPDL_WR_N <= '1;
      end else begin
        r_state <= S_SETUP;
        r_digit <= w_next;
        HPDL_A <= ~w_next[1:0];
        HPDL_D <= w_caret ? CARET_CHR[6:0] : r_buf[w_next];
      end
    end
  end
endmodule

// File: tb/tb_hpdl_multi_display.sv
// tb_hpdl_multi_display: directed checks of editing, clear, scan timing, caret and async reset
module tb_hpdl_multi_display;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       mode_scroll = 1'b0;
  logic       caret_en = 1'b0;
  logic [6:0] HPDL_D;
  logic [1:0] HPDL_A;
  logic [1:0] HPDL_WR_N;
  logic [3:0] cursor;
  int checks = 0;
  int errors = 0;

  hpdl_multi_display_if m();

  hpdl_multi_display #(
    .NUM_CHIPS(2), .SETUP_CYC(2), .WR_CYC(3), .HOLD_CYC(2), .BLINK_DIV(64)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .s(m), .mode_scroll(mode_scroll), .caret_en(caret_en),
    .HPDL_D(HPDL_D), .HPDL_A(HPDL_A), .HPDL_WR_N(HPDL_WR_N), .cursor(cursor)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    m.in_data = b;
    m.in_valid = 1'b1;
    @(negedge CLK);
    m.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic check_buf(input string tag, input string s);
    for (int i = 0; i < 8; i++) chk($sformatf("%s[%0d]", tag, i), 32'(dut.r_buf[i]), 32'(s[i]));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    int found, low, n5f, nb, noth;
    logic [1:0] ew;
    m.in_valid = 1'b0;
    m.in_data = 8'h00;
    repeat (2) @(negedge CLK);
    chk("rst_wr_n", HPDL_WR_N, 2'b11);
    chk("rst_a", HPDL_A, 2'b11);
    chk("rst_d", HPDL_D, 0);
    chk("rst_ready", m.in_ready, 1);
    chk("rst_cursor", cursor, 0);
    check_buf("rst_buf", "        ");
    RST_N = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      int d, p;
      @(negedge CLK);
      d = (c / 7) % 8;
      p = c % 7;
      ew = (p >= 2 && p <= 4) ? ~(2'b01 << (d / 4)) : 2'b11;
      chk($sformatf("idle_wr_n_c%0d", c), HPDL_WR_N, ew);
      if (p >= 2 && p <= 4) begin
        chk($sformatf("idle_a_c%0d", c), HPDL_A, 3 - (d % 4));
        chk($sformatf("idle_d_c%0d", c), HPDL_D, (c < 7) ? 0 : 'h20);
      end
    end

    send_str("HELLO");
    chk("hello_cursor", cursor, 5);
    check_buf("hello_buf", "HELLO   ");
    repeat (56) @(negedge CLK);
    found = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (HPDL_WR_N == 2'b01 && HPDL_A == 2'b11) begin
        found = 1;
        break;
      end
    end
    chk("hello_strobe_found", found, 1);
    chk("hello_d4", HPDL_D, 'h4F);

    do_reset();
    mode_scroll = 1'b1;
    send_str("ABCDEFGHI");
    chk("scroll_cursor", cursor, 8);
    check_buf("scroll_buf", "BCDEFGHI");
    send(8'h7F);
    chk("scroll_7f_last", dut.r_buf[7], 'h7F);
    chk("scroll_7f_first", dut.r_buf[0], "C");
    chk("scroll_7f_cursor", cursor, 8);

    do_reset();
    mode_scroll = 1'b0;
    send_str("ABCDEFGHI");
    chk("wrap_cursor", cursor, 1);
    check_buf("wrap_buf", "IBCDEFGH");

    do_reset();
    send_str("ABC");
    send(8'h08);
    chk("bksp_cursor", cursor, 2);
    check_buf("bksp_buf", "AB      ");
    send(8'h08);
    send(8'h08);
    chk("bksp_zero", cursor, 0);
    send(8'h08);
    chk("bksp_at_zero", cursor, 0);
    check_buf("bksp_blank", "        ");
    send(8'h80);
    send(8'h1B);
    chk("ignored_cursor", cursor, 0);
    check_buf("ignored_buf", "        ");
    send_str("XY");
    send(8'h0D);
    chk("cr_cursor", cursor, 0);
    check_buf("cr_buf", "XY      ");

    send_str("QWERTYUI");
    chk("fill_cursor", cursor, 8);
    m.in_data = 8'h0C;
    m.in_valid = 1'b1;
    low = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (m.in_ready) break;
      low++;
    end
    chk("clr_ready_low", low, 8);
    check_buf("clr_buf", "        ");
    chk("clr_cursor", cursor, 0);
    m.in_data = "Z";
    @(negedge CLK);
    m.in_valid = 1'b0;
    chk("clr_next_byte", dut.r_buf[0], "Z");
    chk("clr_next_cursor", cursor, 1);

    do_reset();
    caret_en = 1'b1;
    send_str("AB");
    send(8'h0D);
    send("A");
    chk("caret_cursor", cursor, 1);
    repeat (60) @(negedge CLK);
    n5f = 0; nb = 0; noth = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      if (HPDL_WR_N == 2'b10 && HPDL_A == 2'b10) begin
        if (HPDL_D == 7'h5F) n5f++;
        else if (HPDL_D == 7'h42) nb++;
        else noth++;
      end
    end
    chk("caret_shown", n5f > 0, 1);
    chk("caret_char_shown", nb > 0, 1);
    chk("caret_other", noth, 0);
    caret_en = 1'b0;
    repeat (60) @(negedge CLK);
    n5f = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (HPDL_WR_N != 2'b11 && HPDL_D == 7'h5F) n5f++;
    end
    chk("caret_disabled", n5f, 0);

    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (HPDL_WR_N != 2'b11) begin
        found = 1;
        break;
      end
    end
    chk("strobe_before_reset", found, 1);
    #1 RST_N = 1'b0;
    #1;
    chk("async_wr_n", HPDL_WR_N, 2'b11);
    chk("async_a", HPDL_A, 2'b11);
    chk("async_d", HPDL_D, 0);
    chk("async_cursor", cursor, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
